// File: rtl/rally_referee_pkg.sv
// Shared types and default geometry/timing for the rally referee.
package rally_referee_pkg;

    typedef enum logic [2:0] {REF_SERVE, REF_RALLY, REF_AWARD, REF_PAUSE, REF_OVER} referee_state_t;
    typedef enum logic [1:0] {HIT_NONE, HIT_P1, HIT_P2} hitter_t;

    localparam int unsigned NET_X_DEF        = 32'd320;
    localparam int unsigned COURT_LEFT_DEF   = 32'd40;
    localparam int unsigned COURT_RIGHT_DEF  = 32'd600;
    localparam int unsigned HOLD_CYCLES_DEF  = 32'd4;
    localparam int unsigned PAUSE_FRAMES_DEF = 32'd60;
    localparam int unsigned CNT_W            = 32'd8;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/rally_referee_tick_counter.sv
// Loadable down-counter; holds at zero. Load wins over decrement.
module tick_counter #(
    parameter int unsigned WIDTH = 32'd8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // count register with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst_n) begin
            count <= {WIDTH{1'b0}};
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != {WIDTH{1'b0}})) begin
            count <= count - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/rally_referee.sv
// Rally referee: judges serves, hits and landings, and issues one held add-score pulse per point.
module rally_referee
    import rally_referee_pkg::*;
#(
    parameter int unsigned NET_X        = NET_X_DEF,
    parameter int unsigned COURT_LEFT   = COURT_LEFT_DEF,
    parameter int unsigned COURT_RIGHT  = COURT_RIGHT_DEF,
    parameter int unsigned HOLD_CYCLES  = HOLD_CYCLES_DEF,
    parameter int unsigned PAUSE_FRAMES = PAUSE_FRAMES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic [11:0] shuttle_x,
    input  logic        shuttle_landed,
    input  logic        hit_p1,
    input  logic        hit_p2,
    input  logic        game_over,
    output logic        player1_add_score,
    output logic        player2_add_score,
    output logic        serve_side,
    output logic        play_enable,
    output logic        shuttle_reset,
    output logic [7:0]  rally_hits
);

    localparam logic [11:0]      NET_X_S       = 12'(NET_X);
    localparam logic [11:0]      COURT_LEFT_S  = 12'(COURT_LEFT);
    localparam logic [11:0]      COURT_RIGHT_S = 12'(COURT_RIGHT);
    // Counters run N-1 .. 0 so the terminal cycle is simply "count is zero".
    localparam logic [CNT_W-1:0] HOLD_LOAD     = CNT_W'(HOLD_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] PAUSE_LOAD    = CNT_W'(PAUSE_FRAMES - 32'd1);

    referee_state_t   state_r, state_nxt_s;
    hitter_t          last_hitter_r, last_hitter_nxt_s, new_hitter_s;
    logic             award_s, winner_s, hit_valid_s, server_hit_s;
    logic             in_bounds_s, land_winner_s;
    logic [CNT_W-1:0] ctr_count_s, ctr_load_val_s;
    logic             ctr_zero_s, ctr_load_s, ctr_en_s;
    logic             p1_add_r, p2_add_r, serve_side_r, play_enable_r, shuttle_reset_r;
    logic             p1_add_nxt_s, p2_add_nxt_s, serve_side_nxt_s, play_enable_nxt_s, shuttle_reset_nxt_s;
    logic [7:0]       rally_hits_r, rally_hits_nxt_s;

    tick_counter #(.WIDTH(CNT_W)) u_tick_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ctr_load_s),
        .load_val (ctr_load_val_s),
        .en       (ctr_en_s),
        .count    (ctr_count_s)
    );

    assign ctr_zero_s = (ctr_count_s == {CNT_W{1'b0}});

    // landing classifier: winner 0 = player 1, 1 = player 2
    always_comb begin
        in_bounds_s = (shuttle_x >= COURT_LEFT_S) && (shuttle_x <= COURT_RIGHT_S);
        if (in_bounds_s) begin
            land_winner_s = (shuttle_x < NET_X_S) ? 1'b1 : 1'b0;
        end else begin
            land_winner_s = (last_hitter_r == HIT_P2) ? 1'b0 : 1'b1;
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_r <= REF_SERVE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // next-state logic and point/hit decisions
    always_comb begin
        state_nxt_s  = state_r;
        award_s      = 1'b0;
        winner_s     = 1'b0;
        hit_valid_s  = 1'b0;
        new_hitter_s = last_hitter_r;
        server_hit_s = serve_side_r ? hit_p2 : hit_p1;
        case (state_r)
            REF_SERVE: begin
                if (shuttle_landed) begin
                    award_s     = 1'b1;
                    winner_s    = ~serve_side_r;
                    state_nxt_s = REF_AWARD;
                end else if (server_hit_s) begin
                    hit_valid_s  = 1'b1;
                    new_hitter_s = serve_side_r ? HIT_P2 : HIT_P1;
                    state_nxt_s  = REF_RALLY;
                end else begin
                    state_nxt_s = REF_SERVE;
                end
            end
            REF_RALLY: begin
                if (shuttle_landed) begin
                    award_s     = 1'b1;
                    winner_s    = land_winner_s;
                    state_nxt_s = REF_AWARD;
                end else if (hit_p1 && hit_p2) begin
                    hit_valid_s  = 1'b1;
                    new_hitter_s = (last_hitter_r == HIT_P1) ? HIT_P2 : HIT_P1;
                end else if (hit_p1) begin
                    if (last_hitter_r == HIT_P1) begin
                        award_s     = 1'b1;
                        winner_s    = 1'b1;
                        state_nxt_s = REF_AWARD;
                    end else begin
                        hit_valid_s  = 1'b1;
                        new_hitter_s = HIT_P1;
                    end
                end else if (hit_p2) begin
                    if (last_hitter_r == HIT_P2) begin
                        award_s     = 1'b1;
                        winner_s    = 1'b0;
                        state_nxt_s = REF_AWARD;
                    end else begin
                        hit_valid_s  = 1'b1;
                        new_hitter_s = HIT_P2;
                    end
                end else begin
                    state_nxt_s = REF_RALLY;
                end
            end
            REF_AWARD: begin
                if (ctr_zero_s) begin
                    state_nxt_s = REF_PAUSE;
                end else begin
                    state_nxt_s = REF_AWARD;
                end
            end
            REF_PAUSE: begin
                if (frame_tick && ctr_zero_s) begin
                    state_nxt_s = game_over ? REF_OVER : REF_SERVE;
                end else begin
                    state_nxt_s = REF_PAUSE;
                end
            end
            REF_OVER:  state_nxt_s = REF_OVER;
            default:   state_nxt_s = REF_SERVE;
        endcase
    end

    // next values of the registered outputs and the shared counter controls
    always_comb begin
        serve_side_nxt_s    = award_s ? winner_s : serve_side_r;
        p1_add_nxt_s        = (state_nxt_s == REF_AWARD) && !serve_side_nxt_s;
        p2_add_nxt_s        = (state_nxt_s == REF_AWARD) && serve_side_nxt_s;
        play_enable_nxt_s   = (state_nxt_s == REF_SERVE) || (state_nxt_s == REF_RALLY);
        shuttle_reset_nxt_s = (state_r == REF_PAUSE) && (state_nxt_s == REF_SERVE);
        if (hit_valid_s) begin
            last_hitter_nxt_s = new_hitter_s;
            rally_hits_nxt_s  = (state_r == REF_SERVE) ? 8'd1 : sat_inc8(rally_hits_r);
        end else if (shuttle_reset_nxt_s) begin
            last_hitter_nxt_s = HIT_NONE;
            rally_hits_nxt_s  = 8'd0;
        end else begin
            last_hitter_nxt_s = last_hitter_r;
            rally_hits_nxt_s  = rally_hits_r;
        end
        if (award_s) begin
            ctr_load_s     = 1'b1;
            ctr_load_val_s = HOLD_LOAD;
        end else if ((state_r == REF_AWARD) && (state_nxt_s == REF_PAUSE)) begin
            ctr_load_s     = 1'b1;
            ctr_load_val_s = PAUSE_LOAD;
        end else begin
            ctr_load_s     = 1'b0;
            ctr_load_val_s = HOLD_LOAD;
        end
        ctr_en_s = (state_r == REF_AWARD) || ((state_r == REF_PAUSE) && frame_tick);
    end

    // output and rally bookkeeping registers
    always_ff @(posedge clk) begin
        if (rst_n) begin
            p1_add_r        <= 1'b0;
            p2_add_r        <= 1'b0;
            serve_side_r    <= 1'b0;
            play_enable_r   <= 1'b1;
            shuttle_reset_r <= 1'b0;
            rally_hits_r    <= 8'd0;
            last_hitter_r   <= HIT_NONE;
        end else begin
            p1_add_r        <= p1_add_nxt_s;
            p2_add_r        <= p2_add_nxt_s;
            serve_side_r    <= serve_side_nxt_s;
            play_enable_r   <= play_enable_nxt_s;
            shuttle_reset_r <= shuttle_reset_nxt_s;
            rally_hits_r    <= rally_hits_nxt_s;
            last_hitter_r   <= last_hitter_nxt_s;
        end
    end

    assign player1_add_score = p1_add_r;
    assign player2_add_score = p2_add_r;
    assign serve_side        = serve_side_r;
    assign play_enable       = play_enable_r;
    assign shuttle_reset     = shuttle_reset_r;
    assign rally_hits        = rally_hits_r;

endmodule

// File: tb/tb_rally_referee.sv
// Directed bench for rally_referee: a rules-level model checked every cycle plus literal spot checks.
module tb_rally_referee;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        frame_tick = 1'b0;
    logic [11:0] shuttle_x = 12'd0;
    logic        shuttle_landed = 1'b0;
    logic        hit_p1 = 1'b0;
    logic        hit_p2 = 1'b0;
    logic        game_over = 1'b0;
    logic        player1_add_score, player2_add_score, serve_side, play_enable, shuttle_reset;
    logic [7:0]  rally_hits;

    int checks = 0;
    int failures = 0;

    rally_referee dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .frame_tick        (frame_tick),
        .shuttle_x         (shuttle_x),
        .shuttle_landed    (shuttle_landed),
        .hit_p1            (hit_p1),
        .hit_p2            (hit_p2),
        .game_over         (game_over),
        .player1_add_score (player1_add_score),
        .player2_add_score (player2_add_score),
        .serve_side        (serve_side),
        .play_enable       (play_enable),
        .shuttle_reset     (shuttle_reset),
        .rally_hits        (rally_hits)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Rules model: phase 0 serve, 1 rally, 2 point shown, 3 frozen, 4 match over.
    int m_phase, m_last, m_hits, m_hold, m_ticks, m_server, m_winner;
    bit m_sreset, m_valid;

    task automatic give_point(input int w);
        m_phase  = 2;
        m_winner = w;
        m_server = w;
        m_hold   = 4;
    endtask

    task automatic model_step();
        int h;
        int xv;
        m_sreset = 1'b0;
        xv = int'(shuttle_x);
        if (rst_n) begin
            m_phase = 0; m_last = 0; m_hits = 0; m_server = 0; m_valid = 1'b1;
        end else if (m_phase == 0) begin
            if (shuttle_landed) give_point(1 - m_server);
            else if ((m_server == 0 && hit_p1) || (m_server == 1 && hit_p2)) begin
                m_phase = 1; m_last = m_server + 1; m_hits = 1;
            end
        end else if (m_phase == 1) begin
            if (shuttle_landed) begin
                if (xv >= 40 && xv <= 600) give_point(xv < 320 ? 1 : 0);
                else give_point(m_last == 1 ? 1 : 0);
            end else if (hit_p1 || hit_p2) begin
                if (hit_p1 && hit_p2) h = (m_last == 1) ? 2 : 1;
                else h = hit_p1 ? 1 : 2;
                if (h == m_last) give_point(m_last == 1 ? 1 : 0);
                else begin
                    m_last = h;
                    if (m_hits < 255) m_hits++;
                end
            end
        end else if (m_phase == 2) begin
            m_hold--;
            if (m_hold == 0) begin m_phase = 3; m_ticks = 60; end
        end else if (m_phase == 3) begin
            if (frame_tick) begin
                m_ticks--;
                if (m_ticks == 0) begin
                    if (game_over) m_phase = 4;
                    else begin m_phase = 0; m_sreset = 1'b1; m_hits = 0; m_last = 0; end
                end
            end
        end
    endtask

    // per-cycle compare against the model, sampled on the falling edge
    initial begin
        m_valid = 1'b0;
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            if (m_valid) begin
                chk("model_p1_add", int'(player1_add_score), (m_phase == 2 && m_winner == 0) ? 1 : 0);
                chk("model_p2_add", int'(player2_add_score), (m_phase == 2 && m_winner == 1) ? 1 : 0);
                chk("model_serve_side", int'(serve_side), m_server);
                chk("model_play_enable", int'(play_enable), (m_phase < 2) ? 1 : 0);
                chk("model_shuttle_reset", int'(shuttle_reset), int'(m_sreset));
                chk("model_rally_hits", int'(rally_hits), m_hits);
            end
        end
    end

    task automatic pulse(input logic h1, input logic h2, input logic ld, input logic [11:0] x);
        hit_p1 = h1; hit_p2 = h2; shuttle_landed = ld; shuttle_x = x;
        @(negedge clk);
        hit_p1 = 1'b0; hit_p2 = 1'b0; shuttle_landed = 1'b0; shuttle_x = 12'd0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
        end
    endtask

    // Called on the falling edge right after the deciding edge.
    task automatic do_point(input string nm, input int who, input bit over);
        int w;
        chk({nm, "_p1"}, int'(player1_add_score), (who == 1) ? 1 : 0);
        chk({nm, "_p2"}, int'(player2_add_score), (who == 2) ? 1 : 0);
        chk({nm, "_serve"}, int'(serve_side), who - 1);
        w = 0;
        while ((player1_add_score || player2_add_score) && w < 20) begin
            w++;
            @(negedge clk);
        end
        chk({nm, "_hold_len"}, w, 4);
        frames(60);
        chk({nm, "_sreset"}, int'(shuttle_reset), over ? 0 : 1);
        chk({nm, "_play"}, int'(play_enable), over ? 0 : 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        chk("reset_play", int'(play_enable), 1);
        chk("reset_serve", int'(serve_side), 0);
        chk("reset_hits", int'(rally_hits), 0);
        @(negedge clk);

        pulse(1'b1, 1'b0, 1'b0, 12'd0);
        pulse(1'b0, 1'b1, 1'b0, 12'd0);
        pulse(1'b0, 1'b0, 1'b1, 12'd500);
        chk("t1_hits", int'(rally_hits), 2);
        do_point("t1", 1, 1'b0);

        pulse(1'b1, 1'b0, 1'b0, 12'd0);
        pulse(1'b0, 1'b0, 1'b1, 12'd100);
        do_point("t2", 2, 1'b0);

        pulse(1'b0, 1'b1, 1'b0, 12'd0);
        pulse(1'b1, 1'b0, 1'b0, 12'd0);
        pulse(1'b0, 1'b0, 1'b1, 12'd620);
        do_point("t3_out", 2, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 12'd0);
        pulse(1'b1, 1'b0, 1'b0, 12'd0);
        pulse(1'b1, 1'b0, 1'b0, 12'd0);
        chk("t3_dbl_hits", int'(rally_hits), 2);
        do_point("t3_dbl", 2, 1'b0);

        pulse(1'b0, 1'b0, 1'b1, 12'd300);
        do_point("t4_fault", 1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 12'd0);
        chk("t4_recv_ignored", int'(rally_hits), 0);
        pulse(1'b1, 1'b0, 1'b0, 12'd0);
        chk("t4_serve_hits", int'(rally_hits), 1);

        pulse(1'b0, 1'b1, 1'b1, 12'd700);
        do_point("t5_land_wins", 2, 1'b0);

        pulse(1'b1, 1'b1, 1'b0, 12'd0);
        pulse(1'b1, 1'b1, 1'b0, 12'd0);
        chk("both_hits", int'(rally_hits), 2);
        pulse(1'b0, 1'b0, 1'b1, 12'd330);
        do_point("both", 1, 1'b0);

        pulse(1'b1, 1'b0, 1'b0, 12'd0);
        pulse(1'b0, 1'b0, 1'b1, 12'd40);
        do_point("x40", 2, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 12'd0);
        pulse(1'b0, 1'b0, 1'b1, 12'd600);
        do_point("x600", 1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 12'd0);
        pulse(1'b0, 1'b0, 1'b1, 12'd320);
        do_point("x320", 1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 12'd0);
        pulse(1'b0, 1'b0, 1'b1, 12'd39);
        do_point("x39", 2, 1'b0);

        pulse(1'b0, 1'b1, 1'b0, 12'd0);
        for (int i = 0; i < 260; i++) pulse(i % 2 == 0, i % 2 == 1, 1'b0, 12'd0);
        chk("sat_hits", int'(rally_hits), 255);
        pulse(1'b0, 1'b0, 1'b1, 12'd601);
        do_point("sat", 1, 1'b0);

        pulse(1'b1, 1'b0, 1'b0, 12'd0);
        pulse(1'b0, 1'b0, 1'b1, 12'd500);
        game_over = 1'b1;
        do_point("over", 1, 1'b1);
        pulse(1'b1, 1'b0, 1'b0, 12'd0);
        pulse(1'b0, 1'b0, 1'b1, 12'd500);
        game_over = 1'b0;
        repeat (3) @(negedge clk);
        chk("over_quiet_p1", int'(player1_add_score), 0);
        chk("over_play", int'(play_enable), 0);

        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        pulse(1'b1, 1'b0, 1'b0, 12'd0);
        pulse(1'b0, 1'b0, 1'b1, 12'd100);
        chk("mid_award_p2", int'(player2_add_score), 1);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        chk("rst_award_p2", int'(player2_add_score), 0);
        chk("rst_award_play", int'(play_enable), 1);
        chk("rst_award_serve", int'(serve_side), 0);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
